iomem_arbiter: RTL and testbench

//  Two-master arbiter for the picosoc iomem peripheral bus. Shares one slave-side iomem port (the

---
 rtl/iomem_arb_pkg.sv | 24 ++
 rtl/iomem_arb_timer.sv | 34 +++
 rtl/iomem_arbiter.sv | 143 ++++++++++++++
 tb/tb_iomem_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/iomem_arb_pkg.sv
// iomem_arb_pkg
//   Shared definitions for the two-master iomem arbiter: FSM state encoding,
//   default abort read data, master index constants and the round-robin pick.
package iomem_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_t;

  localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // On a tie the master that did not win last time takes the bus, so a
  // master that keeps requesting can never lock the other one out.
  function automatic logic rr_pick(input logic v0, input logic v1, input logic last);
    if (v0 && v1)  return ~last;
    else if (v1)   return M1;
    else           return M0;
  endfunction

endpackage

// File: rtl/iomem_arb_timer.sv
// iomem_arb_timer
//   Bus-timeout counter for the iomem arbiter.
//   Ports:
//     clk, reset  clock, asynchronous active-high reset
//     i_clr       clear counter to zero (new grant)
//     i_en        count one stalled cycle
//     o_last      counter is at LIMIT-1: the current stalled cycle is the last allowed
module iomem_arb_timer
  import iomem_arb_pkg::*;
#(
  parameter int unsigned LIMIT = 255,
  parameter int unsigned CNT_W = 8
)(
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_last
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);
  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + ONE;
  end

  assign o_last = (r_cnt == LAST);

endmodule

// File: rtl/iomem_arbiter.sv
// iomem_arbiter
//   Round-robin arbiter sharing the picosoc iomem peripheral port between the
//   CPU (m0) and a second master (m1). One transaction in flight; a grant takes
//   one IDLE cycle, after which the owner's request is passed straight through.
//   Optional bus timeout is compiled in when IOMEM_TIMEOUT_EN is defined.
//   Ports:
//     clk, reset                     clock, asynchronous active-high reset
//     m{0,1}_valid/wstrb/addr/wdata  master requests (wstrb==0 is a read)
//     m{0,1}_ready/rdata             single-cycle completion and read data
//     s_valid/wstrb/addr/wdata       request to the peripheral fabric
//     s_ready/s_rdata                fabric completion and read data
//     grant_id                       current/last owner (0=m0, 1=m1)
//     busy                           transaction in flight
//     err_pulse, err_addr            timeout abort pulse and address of last abort
module iomem_arbiter
  import iomem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEF
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        grant_id,
  output logic        busy,
  output logic        err_pulse,
  output logic [31:0] err_addr
);

  arb_state_t  r_state;
  logic        r_owner;
  logic        r_last_winner;

  logic        w_own;
  logic        w_any_req;
  logic        w_winner;
  logic        w_own_valid;
  logic        w_expire;
  logic        w_done;
  logic [31:0] w_rdata;

  assign w_own     = (r_state == ST_OWN);
  assign w_any_req = m0_valid | m1_valid;
  assign w_winner  = rr_pick(m0_valid, m1_valid, r_last_winner);

  // Owner's request fields go straight to the fabric with no extra latency.
  assign w_own_valid = (r_owner == M1) ? m1_valid : m0_valid;
  assign s_wstrb     = (r_owner == M1) ? m1_wstrb : m0_wstrb;
  assign s_addr      = (r_owner == M1) ? m1_addr  : m0_addr;
  assign s_wdata     = (r_owner == M1) ? m1_wdata : m0_wdata;

  // On expiry the fabric request is withdrawn in the same cycle the master
  // is released, so the fabric never sees a dangling request.
  assign s_valid = w_own & w_own_valid & ~w_expire;

  // A master that drops valid while owning aborts silently: no ready pulse.
  assign w_done  = w_own & w_own_valid & (s_ready | w_expire);
  assign w_rdata = w_expire ? ERR_RDATA : s_rdata;

  assign m0_ready = w_done & (r_owner == M0);
  assign m1_ready = w_done & (r_owner == M1);
  assign m0_rdata = m0_ready ? w_rdata : '0;
  assign m1_rdata = m1_ready ? w_rdata : '0;

  assign grant_id = r_owner;
  assign busy     = w_own;

`ifdef IOMEM_TIMEOUT_EN
  logic        w_tmr_last;
  logic [31:0] r_err_addr;

  iomem_arb_timer #(
    .LIMIT (TIMEOUT_CYCLES),
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (~w_own & w_any_req),
    .i_en   (w_own & ~s_ready),
    .o_last (w_tmr_last)
  );

  // A fabric completion in the expiry cycle wins over the timeout.
  assign w_expire = w_own & w_own_valid & ~s_ready & w_tmr_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_err_addr <= '0;
    else if (w_expire) r_err_addr <= s_addr;
  end

  assign err_pulse = w_expire;
  assign err_addr  = r_err_addr;
`else
  logic [31:0] w_unused_cfg;

  assign w_unused_cfg = TIMEOUT_CYCLES ^ CNT_W;
  assign w_expire     = 1'b0;
  assign err_pulse    = 1'b0;
  assign err_addr     = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_owner       <= M0;
      r_last_winner <= M1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_owner       <= w_winner;
            r_last_winner <= w_winner;
            r_state       <= ST_OWN;
          end
        end
        ST_OWN: begin
          // Always pass through IDLE so every transaction re-arbitrates.
          if (!w_own_valid || s_ready || w_expire) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iomem_arbiter.sv
module tb_iomem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_valid, m1_valid;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr, s_wdata;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic        grant_id, busy, err_pulse;
  logic [31:0] err_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iomem_arbiter #(
    .TIMEOUT_CYCLES (16),
    .CNT_W          (8),
    .ERR_RDATA      (32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_wstrb(s_wstrb), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .grant_id(grant_id), .busy(busy), .err_pulse(err_pulse), .err_addr(err_addr)
  );

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; s_ready = 1'b1;
    #3;
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL rst_svalid got %b exp 0", s_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL rst_grant got %b exp 0", grant_id); end
    checks++; if ({m0_ready, m1_ready} !== 2'b00) begin errors++; $display("FAIL rst_ready got %b exp 00", {m0_ready, m1_ready}); end
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL rst_errp got %b exp 0", err_pulse); end
    checks++; if (err_addr !== 32'h0) begin errors++; $display("FAIL rst_erraddr got %h exp 0", err_addr); end
    tick; s_ready = 1'b0; reset = 1'b0;
  endtask

  task automatic test_m0_read;
    m0_valid = 1'b1; m0_addr = 32'h0300_0000; m0_wstrb = 4'h0; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_latency busy got %b exp 0", busy); end
    tick;
    checks++; if ({busy, s_valid, grant_id} !== 3'b110) begin errors++; $display("FAIL rd_grant got %b exp 110", {busy, s_valid, grant_id}); end
    checks++; if (s_addr !== 32'h0300_0000) begin errors++; $display("FAIL rd_saddr got %h exp 03000000", s_addr); end
    tick; tick;
    checks++; if (m0_ready !== 1'b0) begin errors++; $display("FAIL rd_early got %b exp 0", m0_ready); end
    tick; s_ready = 1'b1; s_rdata = 32'h0000_00A5; #1;
    checks++; if (m0_ready !== 1'b1) begin errors++; $display("FAIL rd_ready got %b exp 1", m0_ready); end
    checks++; if (m0_rdata !== 32'h0000_00A5) begin errors++; $display("FAIL rd_rdata got %h exp 000000a5", m0_rdata); end
    checks++; if ({m1_ready, m1_rdata} !== 33'h0) begin errors++; $display("FAIL rd_m1quiet got %h exp 0", {m1_ready, m1_rdata}); end
    tick; s_ready = 1'b0; m0_valid = 1'b0; #1;
    checks++; if ({m0_ready, busy} !== 2'b00) begin errors++; $display("FAIL rd_after got %b exp 00", {m0_ready, busy}); end
  endtask

  task automatic test_round_robin;
    reset = 1'b1; tick; reset = 1'b0;
    m0_valid = 1'b1; m0_addr = 32'h0300_00A0; m0_wstrb = 4'h0;
    m1_valid = 1'b1; m1_addr = 32'h0300_00A1; m1_wstrb = 4'h0;
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++; if (grant_id !== i[0]) begin errors++; $display("FAIL rr_grant%0d got %b exp %b", i, grant_id, i[0]); end
      s_ready = 1'b1; s_rdata = 32'h100 + i; #1;
      checks++;
      if ({m0_ready, m1_ready} !== (i[0] ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL rr_ready%0d got %b exp %b", i, {m0_ready, m1_ready}, (i[0] ? 2'b01 : 2'b10));
      end
      tick; s_ready = 1'b0;
    end
    m0_valid = 1'b0; m1_valid = 1'b0;
    tick;
  endtask

  task automatic test_write_stall;
    logic bad;
    m1_valid = 1'b1; m1_wstrb = 4'hF; m1_addr = 32'h0500_0010; m1_wdata = 32'h1234_5678;
    tick;
    checks++; if ({s_valid, grant_id} !== 2'b11) begin errors++; $display("FAIL wr_grant got %b exp 11", {s_valid, grant_id}); end
    checks++;
    if ({s_wstrb, s_addr, s_wdata} !== {4'hF, 32'h0500_0010, 32'h1234_5678}) begin
      errors++; $display("FAIL wr_fields got %h %h %h exp f 05000010 12345678", s_wstrb, s_addr, s_wdata);
    end
    m0_valid = 1'b1; m0_wstrb = 4'h0; m0_addr = 32'h0300_0004;
    bad = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (m0_ready !== 1'b0 || grant_id !== 1'b1 || s_addr !== 32'h0500_0010) bad = 1'b1;
      tick;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL wr_m0stall got %b exp 0", bad); end
    s_ready = 1'b1; s_rdata = 32'h0; #1;
    checks++; if ({m1_ready, m0_ready} !== 2'b10) begin errors++; $display("FAIL wr_done got %b exp 10", {m1_ready, m0_ready}); end
    tick; s_ready = 1'b0; m1_valid = 1'b0; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_idlegap got %b exp 0", busy); end
    tick;
    checks++; if ({grant_id, s_addr} !== {1'b0, 32'h0300_0004}) begin errors++; $display("FAIL wr_m0next got %b %h exp 0 03000004", grant_id, s_addr); end
    s_ready = 1'b1; s_rdata = 32'h77; #1;
    checks++; if ({m0_ready, m0_rdata} !== {1'b1, 32'h77}) begin errors++; $display("FAIL wr_m0done got %b %h exp 1 00000077", m0_ready, m0_rdata); end
    tick; s_ready = 1'b0; m0_valid = 1'b0;
    tick;
  endtask

  task automatic test_abort;
    m0_valid = 1'b1; m0_addr = 32'h0400_0000;
    tick;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ab_busy got %b exp 1", busy); end
    m0_valid = 1'b0; #1;
    checks++; if ({s_valid, m0_ready} !== 2'b00) begin errors++; $display("FAIL ab_drop got %b exp 00", {s_valid, m0_ready}); end
    tick;
    checks++; if ({busy, m0_ready} !== 2'b00) begin errors++; $display("FAIL ab_idle got %b exp 00", {busy, m0_ready}); end
  endtask

  task automatic test_reset_mid;
    m1_valid = 1'b1; m1_addr = 32'h0600_0000; m1_wstrb = 4'h0;
    tick;
    checks++; if ({s_valid, grant_id} !== 2'b11) begin errors++; $display("FAIL rm_own got %b exp 11", {s_valid, grant_id}); end
    reset = 1'b1; s_ready = 1'b1; #1;
    checks++;
    if ({s_valid, busy, m0_ready, m1_ready, grant_id} !== 5'b0) begin
      errors++; $display("FAIL rm_async got %b exp 00000", {s_valid, busy, m0_ready, m1_ready, grant_id});
    end
    tick; reset = 1'b0; s_ready = 1'b0;
    m0_valid = 1'b1; m0_addr = 32'h0300_0008; m0_wstrb = 4'h0;
    tick;
    checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL rm_powerup got %b exp 0", grant_id); end
    s_ready = 1'b1; s_rdata = 32'h11; #1;
    checks++; if ({m0_ready, m1_ready} !== 2'b10) begin errors++; $display("FAIL rm_m0done got %b exp 10", {m0_ready, m1_ready}); end
    tick; s_ready = 1'b0; m0_valid = 1'b0;
    tick;
    checks++; if (grant_id !== 1'b1) begin errors++; $display("FAIL rm_m1next got %b exp 1", grant_id); end
    s_ready = 1'b1; #1;
    checks++; if ({m0_ready, m1_ready} !== 2'b01) begin errors++; $display("FAIL rm_m1done got %b exp 01", {m0_ready, m1_ready}); end
    tick; s_ready = 1'b0; m1_valid = 1'b0;
    tick;
  endtask

`ifdef IOMEM_TIMEOUT_EN
  task automatic test_timeout;
    logic bad;
    m0_valid = 1'b1; m0_addr = 32'h0700_0004; m0_wstrb = 4'h0;
    tick;
    bad = 1'b0;
    for (int c = 1; c < 16; c++) begin
      if (m0_ready !== 1'b0 || err_pulse !== 1'b0 || s_valid !== 1'b1) bad = 1'b1;
      tick;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL to_early got %b exp 0", bad); end
    checks++; if ({m0_ready, err_pulse, s_valid} !== 3'b110) begin errors++; $display("FAIL to_expire got %b exp 110", {m0_ready, err_pulse, s_valid}); end
    checks++; if (m0_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL to_rdata got %h exp deadbeef", m0_rdata); end
    tick; m0_valid = 1'b0; #1;
    checks++; if ({err_pulse, busy} !== 2'b00) begin errors++; $display("FAIL to_after got %b exp 00", {err_pulse, busy}); end
    checks++; if (err_addr !== 32'h0700_0004) begin errors++; $display("FAIL to_erraddr got %h exp 07000004", err_addr); end
    m0_valid = 1'b1; m0_addr = 32'h0700_0008;
    tick;
    for (int c = 1; c < 16; c++) tick;
    s_ready = 1'b1; s_rdata = 32'h5A; #1;
    checks++;
    if ({m0_ready, err_pulse, m0_rdata} !== {2'b10, 32'h5A}) begin
      errors++; $display("FAIL to_race got %b %b %h exp 1 0 0000005a", m0_ready, err_pulse, m0_rdata);
    end
    tick; s_ready = 1'b0; m0_valid = 1'b0; #1;
    checks++; if (err_addr !== 32'h0700_0004) begin errors++; $display("FAIL to_erraddr_hold got %h exp 07000004", err_addr); end
    tick;
  endtask
`else
  task automatic test_long_stall;
    logic bad;
    m0_valid = 1'b1; m0_addr = 32'h0600_0000; m0_wstrb = 4'h0;
    tick;
    bad = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (m0_ready !== 1'b0 || err_pulse !== 1'b0 || s_valid !== 1'b1) bad = 1'b1;
      tick;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL ls_stall got %b exp 0", bad); end
    s_ready = 1'b1; s_rdata = 32'hC3; #1;
    checks++;
    if ({m0_ready, err_pulse, m0_rdata} !== {2'b10, 32'hC3}) begin
      errors++; $display("FAIL ls_done got %b %b %h exp 1 0 000000c3", m0_ready, err_pulse, m0_rdata);
    end
    tick; s_ready = 1'b0; m0_valid = 1'b0; #1;
    checks++; if ({m0_ready, busy, err_addr} !== 34'h0) begin errors++; $display("FAIL ls_after got %h exp 0", {m0_ready, busy, err_addr}); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    m0_valid = 1'b0; m0_wstrb = 4'h0; m0_addr = '0; m0_wdata = '0;
    m1_valid = 1'b0; m1_wstrb = 4'h0; m1_addr = '0; m1_wdata = '0;
    s_ready = 1'b0; s_rdata = '0;
    test_reset;
    test_m0_read;
    test_round_robin;
    test_write_stall;
    test_abort;
    test_reset_mid;
`ifdef IOMEM_TIMEOUT_EN
    test_timeout;
`else
    test_long_stall;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
